// File: rtl/gate_seq_pkg.sv
// Shared state encoding and default widths for the gate sequencer.
package gate_seq_pkg;

  localparam int unsigned DEFAULT_CNT_W      = 32;
  localparam int unsigned DEFAULT_PRESCALE_W = 16;
  localparam int unsigned DEFAULT_REP_W      = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    GATE    = 3'd3,
    HOLDOFF = 3'd4
  } state_e;

endpackage

// File: rtl/gate_seq_timer.sv
// Prescaled saturating down-counter; zero_o is a registered "timer == 0" flag.
module gate_seq_timer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [CNT_W-1:0]      load_value_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  zero_o
);

  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  zero_q;

  // Load wins over ticking; a tick only decrements a nonzero timer.
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q + PRESCALE_W'(1);
    if (load_i) begin
      timer_d = load_value_i;
      presc_d = '0;
    end else if (presc_q == prescale_i) begin
      presc_d = '0;
      if (timer_q != '0) timer_d = timer_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      presc_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      timer_q <= timer_d;
      presc_q <= presc_d;
      zero_q  <= (timer_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/gate_sequencer.sv
// Measurement-cycle sequencer: arm, trigger, then DELAY/GATE/HOLDOFF rounds.
module gate_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W,
  parameter int unsigned REP_W      = DEFAULT_REP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic                  trigger_i,
  input  logic                  abort_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0]      delay_i,
  input  logic [CNT_W-1:0]      gate_i,
  input  logic [CNT_W-1:0]      holdoff_i,
  input  logic [REP_W-1:0]      repeats_i,
  output logic                  gate_o,
  output logic                  busy_o,
  output logic                  armed_o,
  output logic                  done_o,
  output logic [REP_W-1:0]      rep_count_o,
  output logic [2:0]            state_o
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [CNT_W-1:0]      delay_q, gate_len_q, holdoff_q;
  logic [REP_W-1:0]      repeats_q, rep_q;
  logic                  gate_q, busy_q, armed_q, done_q, done_d;
  logic                  accept, rep_inc, tmr_load, tmr_zero, last_round;
  logic [CNT_W-1:0]      tmr_value;
  logic [REP_W:0]        rep_next, rep_lim;

  // A repeat count of zero behaves as a single round.
  assign rep_next   = {1'b0, rep_q} + (REP_W+1)'(1);
  assign rep_lim    = (repeats_q == '0) ? (REP_W+1)'(1) : {1'b0, repeats_q};
  assign last_round = (rep_next >= rep_lim);

  gate_seq_timer #(
    .CNT_W      (CNT_W),
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .prescale_i   (prescale_q),
    .zero_o       (tmr_zero)
  );

  // Abort dominates trigger and phase exits in every non-idle state.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    rep_inc   = 1'b0;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      IDLE: if (arm_i) state_d = ARMED;
      ARMED: begin
        if (abort_i) state_d = IDLE;
        else if (trigger_i) begin
          accept    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = delay_i;
          state_d   = DELAY;
        end
      end
      DELAY: begin
        if (abort_i) state_d = IDLE;
        else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = gate_len_q;
          state_d   = GATE;
        end
      end
      GATE: begin
        if (abort_i) state_d = IDLE;
        else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = holdoff_q;
          state_d   = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (abort_i) state_d = IDLE;
        else if (tmr_zero) begin
          rep_inc = 1'b1;
          if (last_round) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = delay_q;
            state_d   = DELAY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      rep_q      <= '0;
      prescale_q <= '0;
      delay_q    <= '0;
      gate_len_q <= '0;
      holdoff_q  <= '0;
      repeats_q  <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= (state_d == GATE);
      busy_q  <= (state_d == DELAY) || (state_d == GATE) || (state_d == HOLDOFF);
      armed_q <= (state_d == ARMED);
      done_q  <= done_d;
      if (accept) begin
        rep_q      <= '0;
        prescale_q <= prescale_i;
        delay_q    <= delay_i;
        gate_len_q <= gate_i;
        holdoff_q  <= holdoff_i;
        repeats_q  <= repeats_i;
      end else if (rep_inc) begin
        rep_q <= rep_next[REP_W-1:0];
      end
    end
  end

  assign gate_o      = gate_q;
  assign busy_o      = busy_q;
  assign armed_o     = armed_q;
  assign done_o      = done_q;
  assign rep_count_o = rep_q;
  assign state_o     = 3'(state_q);

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: vector table plus multi-cycle sequences.
module tb_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst, arm, trig, abort;
  logic [15:0] prescale;
  logic [31:0] delay, gate_len, holdoff;
  logic [15:0] repeats;
  logic        gate_o, busy_o, armed_o, done_o;
  logic [15:0] rep_count_o;
  logic [2:0]  state_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gate_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm),
    .trigger_i   (trig),
    .abort_i     (abort),
    .prescale_i  (prescale),
    .delay_i     (delay),
    .gate_i      (gate_len),
    .holdoff_i   (holdoff),
    .repeats_i   (repeats),
    .gate_o      (gate_o),
    .busy_o      (busy_o),
    .armed_o     (armed_o),
    .done_o      (done_o),
    .rep_count_o (rep_count_o),
    .state_o     (state_o)
  );

  typedef struct {
    logic        rst, arm, trig, abort;
    logic        e_gate, e_busy, e_armed, e_done;
    logic [15:0] e_rep;
    logic [2:0]  e_state;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic g, input logic b, input logic a,
                       input logic d, input logic [15:0] r, input logic [2:0] s);
    logic [22:0] act, expv;
    act  = {gate_o, busy_o, armed_o, done_o, rep_count_o, state_o};
    expv = {g, b, a, d, r, s};
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got gate=%b busy=%b armed=%b done=%b rep=%0d state=%0d, want gate=%b busy=%b armed=%b done=%b rep=%0d state=%0d",
               name, gate_o, busy_o, armed_o, done_o, rep_count_o, state_o, g, b, a, d, r, s);
    end
  endtask

  // P=1, delay=2, gate=3, holdoff=0, repeats=2; config is scrambled after accept.
  task automatic run_basic(input string tag, input logic [15:0] prev_rep);
    logic [2:0]  es;
    logic [15:0] er;
    prescale = 16'd1; delay = 32'd2; gate_len = 32'd3; holdoff = 32'd0; repeats = 16'd2;
    arm = 1'b1; step(); arm = 1'b0;
    check({tag, "_armed"}, 1'b0, 1'b0, 1'b1, 1'b0, prev_rep, 3'd1);
    trig = 1'b1; step(); trig = 1'b0;
    prescale = 16'd3; delay = 32'd7; gate_len = 32'd9; holdoff = 32'd5; repeats = 16'd1;
    for (int k = 1; k <= 28; k++) begin
      if      (k <= 5)  es = 3'd2;
      else if (k <= 12) es = 3'd3;
      else if (k == 13) es = 3'd4;
      else if (k <= 18) es = 3'd2;
      else if (k <= 25) es = 3'd3;
      else if (k == 26) es = 3'd4;
      else              es = 3'd0;
      er = (k <= 13) ? 16'd0 : (k <= 26) ? 16'd1 : 16'd2;
      check($sformatf("%s_k%0d", tag, k), es == 3'd3, es >= 3'd2, 1'b0, k == 27, er, es);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; abort = 1'b0;
    prescale = '0; delay = '0; gate_len = '0; holdoff = '0; repeats = '0;

    //          rst   arm   trig  abort gate  busy  armed done  rep    state
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 3'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 3'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 3'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 3'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 3'd0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 3'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 3'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 3'd0};

    // Zero-length run, gating, and simultaneous-event rows.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; arm = tbl[i].arm; trig = tbl[i].trig; abort = tbl[i].abort;
      step();
      check($sformatf("tbl%0d", i), tbl[i].e_gate, tbl[i].e_busy, tbl[i].e_armed,
            tbl[i].e_done, tbl[i].e_rep, tbl[i].e_state);
    end
    rst = 1'b0; arm = 1'b0; trig = 1'b0; abort = 1'b0;

    run_basic("basic", 16'd1);

    // Abort on the third GATE cycle of round 1.
    prescale = 16'd1; delay = 32'd2; gate_len = 32'd3; holdoff = 32'd0; repeats = 16'd2;
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    for (int k = 1; k < 8; k++) step();
    check("abort_pre", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 3'd3);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_now", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0);
    step();
    check("abort_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0);

    // Reset during HOLDOFF, then a full clean sequence.
    arm = 1'b1; step(); arm = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    for (int k = 1; k < 13; k++) step();
    check("rst_pre", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd4);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_now", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0);
    run_basic("post_rst", 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
